// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: line synchronisers, 11-bit deframer, parity/stop/timeout checks.
// Optional build macro PS2_BREAK_FILTER_EN drops F0 break prefixes together with the byte that follows.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_d;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_prev;
  logic            fall, din, timeout;
  logic [2:0]      bitcnt, bitcnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            par, par_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [7:0]      code_d;
  logic            valid_d, err_d;
`ifdef PS2_BREAK_FILTER_EN
  logic            brk, brk_d;
`endif

  // Index 1 is the synchronised value; clk_prev delays it once more for edge detection.
  assign fall    = clk_prev & ~clk_sync[1];
  assign din     = data_sync[1];
  assign timeout = (state != IDLE) && !fall && (cnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk        <= 1'b0;
`endif
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      state      <= state_d;
      bitcnt     <= bitcnt_d;
      shreg      <= shreg_d;
      par        <= par_d;
      cnt        <= cnt_d;
      code       <= code_d;
      code_valid <= valid_d;
      frame_err  <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      brk        <= brk_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    bitcnt_d = bitcnt;
    shreg_d  = shreg;
    par_d    = par;
    code_d   = code;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_d    = brk;
`endif

    if (fall || state == IDLE)
      cnt_d = '0;
    else if (cnt != TMAX)
      cnt_d = cnt + CW'(1);
    else
      cnt_d = cnt;

    // A fall in the same cycle as the timeout takes priority: the bit is processed instead.
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!din) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shreg_d = {din, shreg[7:1]};
          if (bitcnt == 3'd7) begin
            state_d  = PARITY;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt + 3'd1;
          end
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din && (^{shreg, par})) begin
`ifdef PS2_BREAK_FILTER_EN
            if (brk) begin
              brk_d = 1'b0;
            end else if (shreg == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              code_d  = shreg;
              valid_d = 1'b1;
            end
`else
            code_d  = shreg;
            valid_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            brk_d = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      brk_d   = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: randomized PS/2 frames against a frame-level reference model.
module tb_ps2_rx;

  localparam int T = 600;   // shortened timeout keeps the run brief
  localparam int H = 20;    // PS/2 clock half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_err = 0;
  int         err_seen = 0;
  int         overlap = 0;
  int         hold_viol = 0;
  logic [7:0] held = 8'h00;
  logic [7:0] m_code = 8'h00;
  bit         m_brk = 1'b0;

  ps2_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 8'h00;
    end else begin
      if (code_valid) got_q.push_back(code);
      if (frame_err) err_seen++;
      if (code_valid && frame_err) overlap++;
      if (code_valid) held = code;
      else if (code !== held) hold_viol++;
    end
  end

  // Reference model: outcome of one whole frame. Returns 1 if a pulse is expected.
  function automatic bit model_frame(input logic [7:0] d, input bit ok);
    if (!ok) begin
      exp_err++;
      m_brk = 1'b0;
      return 1'b1;
    end
`ifdef PS2_BREAK_FILTER_EN
    if (m_brk) begin
      m_brk = 1'b0;
      return 1'b0;
    end
    if (d == 8'hF0) begin
      m_brk = 1'b1;
      return 1'b0;
    end
`endif
    exp_q.push_back(d);
    m_code = d;
    return 1'b1;
  endfunction

  // One PS/2 bit; lat = negedges after the pin fall until the first output pulse (-1 if none).
  task automatic ps2_bit(input logic b, output int lat);
    lat = -1;
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int n = 1; n <= H; n++) begin
      @(negedge clk);
      if (lat < 0 && (code_valid || frame_err)) lat = n;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_b, output int lat);
    logic [10:0] bits;
    int l;
    bits = {stop_b, (~(^d)) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], l);
    lat = l;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if (code !== 8'h00) begin mismatched++; $display("FAIL reset_code_in_reset: got %h want 00", code); end
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    compared++;
    if (code !== 8'h00) begin mismatched++; $display("FAIL reset_code_idle: got %h want 00", code); end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL reset_no_valid: got %0d pulses want 0", got_q.size()); end
    compared++;
    if (err_seen != 0) begin mismatched++; $display("FAIL reset_no_err: got %0d pulses want 0", err_seen); end
  endtask

  task automatic test_basic;
    int lat;
    send_frame(8'h45, 1'b0, 1'b1, lat);
    void'(model_frame(8'h45, 1'b1));
    compared++;
    if (lat != 3) begin mismatched++; $display("FAIL basic_latency: got %0d want 3", lat); end
    compared++;
    if (code !== 8'h45) begin mismatched++; $display("FAIL basic_code: got %h want 45", code); end
    compared++;
    if (got_q.size() != 1) begin mismatched++; $display("FAIL basic_valid_count: got %0d want 1", got_q.size()); end
    repeat (200) @(negedge clk);
    compared++;
    if (code !== 8'h45) begin mismatched++; $display("FAIL basic_code_held: got %h want 45", code); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_parity_err;
    int lat;
    send_frame(8'h16, 1'b1, 1'b1, lat);
    void'(model_frame(8'h16, 1'b0));
    compared++;
    if (lat != 3) begin mismatched++; $display("FAIL parity_err_latency: got %0d want 3", lat); end
    compared++;
    if (err_seen != exp_err) begin mismatched++; $display("FAIL parity_err_count: got %0d want %0d", err_seen, exp_err); end
    compared++;
    if (code !== m_code) begin mismatched++; $display("FAIL parity_code_kept: got %h want %h", code, m_code); end
    send_frame(8'h1E, 1'b0, 1'b1, lat);
    void'(model_frame(8'h1E, 1'b1));
    compared++;
    if (code !== 8'h1E) begin mismatched++; $display("FAIL parity_recover_code: got %h want 1e", code); end
    compared++;
    if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL parity_valid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout;
    int l;
    int n_err = -1;
    ps2_bit(1'b0, l);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)), l);
    @(negedge clk);
    ps2_data = 1'($urandom_range(0, 1));
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int n = 1; n <= T + 50; n++) begin
      @(negedge clk);
      if (n == H) ps2_clk = 1'b1;
      if (frame_err && n_err < 0) n_err = n;
    end
    exp_err++;
    m_brk = 1'b0;
    compared++;
    if (n_err < T || n_err > T + 5) begin mismatched++; $display("FAIL timeout_when: got %0d want %0d..%0d", n_err, T, T + 5); end
    compared++;
    if (err_seen != exp_err) begin mismatched++; $display("FAIL timeout_err_count: got %0d want %0d", err_seen, exp_err); end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL timeout_no_valid: got %0d want 0", got_q.size()); end
    send_frame(8'h25, 1'b0, 1'b1, l);
    void'(model_frame(8'h25, 1'b1));
    compared++;
    if (code !== 8'h25) begin mismatched++; $display("FAIL timeout_recover_code: got %h want 25", code); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_break_seq;
    int lat;
    logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b0, 1'b1, lat);
      void'(model_frame(seq[i], 1'b1));
    end
    compared++;
    if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL break_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL break_code[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    compared++;
    if (code !== m_code) begin mismatched++; $display("FAIL break_final_code: got %h want %h", code, m_code); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe;
    int l;
    logic [7:0] d;
    logic       p;
    d = 8'($urandom);
    p = ~(^d);
    ps2_bit(1'b0, l);
    for (int i = 0; i < 5; i++) ps2_bit(d[i], l);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    m_brk = 1'b0;
    m_code = 8'h00;
    @(negedge clk);
    compared++;
    if ({code, code_valid, frame_err} !== 10'h000) begin
      mismatched++;
      $display("FAIL midreset_outputs: got code=%h v=%b e=%b want 00 0 0", code, code_valid, frame_err);
    end
    ps2_bit(d[5], l);
    ps2_bit(d[6], l);
    ps2_bit(d[7], l);
    ps2_bit(p, l);
    ps2_bit(1'b1, l);
    // Any zero among the leftover bits starts a short spurious frame that can only time out.
    if (!(&{d[7:5], p})) exp_err++;
    repeat (T + 100) @(negedge clk);
    compared++;
    if (err_seen != exp_err) begin mismatched++; $display("FAIL midreset_err_count: got %0d want %0d", err_seen, exp_err); end
    compared++;
    if (got_q.size() != 0) begin mismatched++; $display("FAIL midreset_no_valid: got %0d want 0", got_q.size()); end
    send_frame(8'h26, 1'b0, 1'b1, l);
    void'(model_frame(8'h26, 1'b1));
    compared++;
    if (code !== 8'h26) begin mismatched++; $display("FAIL midreset_fresh_code: got %h want 26", code); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int lat, exp_lat, kind;
    logic [7:0] d;
    bit ok;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 7);
      d = (kind == 6) ? 8'hF0 : (kind == 7) ? 8'hE0 : 8'($urandom);
      send_frame(d, kind == 0, kind != 1, lat);
      ok = (kind != 0) && (kind != 1);
      exp_lat = model_frame(d, ok) ? 3 : -1;
      compared++;
      if (lat != exp_lat) begin mismatched++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", f, lat, exp_lat); end
    end
    compared++;
    if (got_q.size() != exp_q.size()) begin mismatched++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL b2b_code[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    compared++;
    if (err_seen != exp_err) begin mismatched++; $display("FAIL b2b_err_count: got %0d want %0d", err_seen, exp_err); end
    compared++;
    if (code !== m_code) begin mismatched++; $display("FAIL b2b_final_code: got %h want %h", code, m_code); end
    compared++;
    if (overlap != 0) begin mismatched++; $display("FAIL pulse_overlap: got %0d cycles want 0", overlap); end
    compared++;
    if (hold_viol != 0) begin mismatched++; $display("FAIL code_hold: got %0d changes without strobe want 0", hold_viol); end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity_err;
    test_timeout;
    test_break_seq;
    test_reset_midframe;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
